// File: rtl/tetris_phase_controller.sv
// tetris_phase_controller
// Control core for one Tetris game: spawn, gravity with lock delay, lock,
// bottom-up scan and one-row-at-a-time clearing through a shift handshake,
// and game-over detection. Strobes and game_over are registered; move_ready
// is the only combinational output.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// IDLE      | waiting for start after reset
// SPAWN     | one cycle: insert a new piece or detect a blocked spawn
// FALL      | active piece under gravity and player moves
// LOCK      | one cycle: lock_en high, datapath merges the piece
// SCAN      | test one row per cycle, bottom to top
// SHIFT     | shift_req held until the datapath acknowledges a row delete
// GAME_OVER | game_over high, waiting for start

module tetris_phase_controller #(
    parameter int ROWS       = 20,
    parameter int LOCK_TICKS = 2
) (
    input  logic                      game_clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      gravity_tick,
    input  logic                      move_valid,
    output logic                      move_ready,
    input  logic                      piece_touching,
    input  logic                      spawn_blocked,
    input  logic [ROWS-1:0]           full_rows,
    output logic                      spawn_req,
    output logic                      fall_en,
    output logic                      lock_en,
    output logic                      shift_req,
    output logic [$clog2(ROWS)-1:0]   shift_row,
    input  logic                      shift_done,
    output logic [$clog2(ROWS+1)-1:0] lines_last,
    output logic [15:0]               line_count,
    output logic                      game_over,
    output logic [2:0]                phase
);

    localparam int IDX_W = $clog2(ROWS);
    localparam int LL_W  = $clog2(ROWS + 1);
    localparam int LC_W  = $clog2(LOCK_TICKS + 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_SPAWN     = 3'd1,
        S_FALL      = 3'd2,
        S_LOCK      = 3'd3,
        S_SCAN      = 3'd4,
        S_SHIFT     = 3'd5,
        S_GAME_OVER = 3'd6
    } state_t;

    state_t            state_q;
    logic [LC_W-1:0]   lock_cnt_q;
    logic [IDX_W-1:0]  scan_idx_q;
    logic [IDX_W-1:0]  shift_row_q;
    logic [LL_W-1:0]   lines_last_q;
    logic [15:0]       line_count_q;
    logic              spawn_req_q;
    logic              fall_en_q;
    logic              lock_en_q;
    logic              shift_req_q;
    logic              game_over_q;

    // Gravity wins over a coincident player move; the move waits a cycle.
    assign move_ready = (state_q == S_FALL) & ~gravity_tick;

    assign spawn_req  = spawn_req_q;
    assign fall_en    = fall_en_q;
    assign lock_en    = lock_en_q;
    assign shift_req  = shift_req_q;
    assign shift_row  = shift_row_q;
    assign lines_last = lines_last_q;
    assign line_count = line_count_q;
    assign game_over  = game_over_q;
    assign phase      = state_q;

    // Phase sequencing with registered strobes; one-cycle strobes default low.
    always_ff @(posedge game_clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            lock_cnt_q   <= '0;
            scan_idx_q   <= '0;
            shift_row_q  <= '0;
            lines_last_q <= '0;
            line_count_q <= '0;
            spawn_req_q  <= 1'b0;
            fall_en_q    <= 1'b0;
            lock_en_q    <= 1'b0;
            shift_req_q  <= 1'b0;
            game_over_q  <= 1'b0;
        end else begin
            spawn_req_q <= 1'b0;
            fall_en_q   <= 1'b0;
            lock_en_q   <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) state_q <= S_SPAWN;
                end
                S_SPAWN: begin
                    if (spawn_blocked) begin
                        game_over_q <= 1'b1;
                        state_q     <= S_GAME_OVER;
                    end else begin
                        spawn_req_q <= 1'b1;
                        lock_cnt_q  <= '0;
                        state_q     <= S_FALL;
                    end
                end
                S_FALL: begin
                    if (gravity_tick) begin
                        if (!piece_touching) begin
                            fall_en_q  <= 1'b1;
                            lock_cnt_q <= '0;
                        end else begin
                            lock_cnt_q <= lock_cnt_q + LC_W'(1);
                            // lock_en rises on the same edge that enters LOCK
                            if (lock_cnt_q == LC_W'(LOCK_TICKS - 1)) begin
                                lock_en_q <= 1'b1;
                                state_q   <= S_LOCK;
                            end
                        end
                    end
                end
                S_LOCK: begin
                    scan_idx_q   <= IDX_W'(ROWS - 1);
                    lines_last_q <= '0;
                    state_q      <= S_SCAN;
                end
                S_SCAN: begin
                    if (full_rows[scan_idx_q]) begin
                        shift_req_q <= 1'b1;
                        shift_row_q <= scan_idx_q;
                        state_q     <= S_SHIFT;
                    end else if (scan_idx_q != '0) begin
                        scan_idx_q <= scan_idx_q - IDX_W'(1);
                    end else begin
                        state_q <= S_SPAWN;
                    end
                end
                S_SHIFT: begin
                    // Same index is rescanned: the row above has dropped into it.
                    if (shift_done) begin
                        shift_req_q  <= 1'b0;
                        lines_last_q <= lines_last_q + LL_W'(1);
                        if (line_count_q != 16'hFFFF)
                            line_count_q <= line_count_q + 16'd1;
                        state_q <= S_SCAN;
                    end
                end
                S_GAME_OVER: begin
                    if (start) begin
                        line_count_q <= '0;
                        lines_last_q <= '0;
                        game_over_q  <= 1'b0;
                        state_q      <= S_SPAWN;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // A refused move request must stay asserted until it is granted.
    a_move_held: assert property (@(posedge game_clk) disable iff (reset)
        (move_valid && !move_ready) |=> move_valid);

endmodule

// File: tb/tb_tetris_phase_controller.sv
module tb_tetris_phase_controller;

    localparam int ROWS = 20;
    localparam int EV_SPAWN = 0;
    localparam int EV_FALL  = 1;
    localparam int EV_LOCK  = 2;
    localparam int EV_SHIFT = 3;
    localparam int EV_GOVER = 4;

    typedef struct {
        int kind;
        int data;
    } ev_t;

    logic            game_clk;
    logic            reset;
    logic            start;
    logic            gravity_tick;
    logic            move_valid;
    logic            move_ready;
    logic            piece_touching;
    logic            spawn_blocked;
    logic [ROWS-1:0] full_rows;
    logic            spawn_req;
    logic            fall_en;
    logic            lock_en;
    logic            shift_req;
    logic [4:0]      shift_row;
    logic            shift_done;
    logic [4:0]      lines_last;
    logic [15:0]     line_count;
    logic            game_over;
    logic [2:0]      phase;

    ev_t exp_q[$];
    int  checks = 0;
    int  errors = 0;

    tetris_phase_controller #(.ROWS(ROWS), .LOCK_TICKS(2)) dut (
        .game_clk       (game_clk),
        .reset          (reset),
        .start          (start),
        .gravity_tick   (gravity_tick),
        .move_valid     (move_valid),
        .move_ready     (move_ready),
        .piece_touching (piece_touching),
        .spawn_blocked  (spawn_blocked),
        .full_rows      (full_rows),
        .spawn_req      (spawn_req),
        .fall_en        (fall_en),
        .lock_en        (lock_en),
        .shift_req      (shift_req),
        .shift_row      (shift_row),
        .shift_done     (shift_done),
        .lines_last     (lines_last),
        .line_count     (line_count),
        .game_over      (game_over),
        .phase          (phase)
    );

    initial begin
        game_clk = 1'b0;
        forever #5 game_clk = ~game_clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1);
    end

    task automatic tick();
        @(posedge game_clk);
        #2;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic push(input int kind, input int data);
        ev_t e;
        e.kind = kind;
        e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic note(input int kind, input int data);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event: got kind=%0d data=%0d, expected none at %0t", kind, data, $time);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.data != data) begin
                errors++;
                $display("FAIL event_order: got kind=%0d data=%0d, expected kind=%0d data=%0d at %0t",
                         kind, data, e.kind, e.data, $time);
            end
        end
    endtask

    // Rows 0..r move down one, row 0 becomes empty.
    function automatic logic [ROWS-1:0] drop_row(input logic [ROWS-1:0] f, input int r);
        logic [ROWS-1:0] n;
        n = f;
        for (int k = r; k > 0; k--) n[k] = f[k-1];
        n[0] = 1'b0;
        return n;
    endfunction

    task automatic wait_sig(input string name, input int which);
        int  n;
        bit  seen;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 60) begin
            tick();
            n++;
            case (which)
                0:       seen = shift_req;
                1:       seen = spawn_req;
                default: seen = game_over;
            endcase
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s: got no assertion within %0d cycles, expected 1", name, n);
        end
    endtask

    task automatic do_shift(input int row);
        wait_sig("shift_req_rise", 0);
        tick();
        shift_done = 1'b1;
        tick();
        shift_done = 1'b0;
        full_rows  = drop_row(full_rows, row);
    endtask

    task automatic lock_piece(input logic [ROWS-1:0] rows);
        piece_touching = 1'b1;
        gravity_tick = 1'b1; tick(); gravity_tick = 1'b0; tick();
        push(EV_LOCK, 3);
        gravity_tick = 1'b1; tick(); gravity_tick = 1'b0;
        full_rows = rows;
        piece_touching = 1'b0;
    endtask

    // Monitor: every strobe pulse and every rise of shift_req/game_over is an event.
    initial begin
        bit prev_shift;
        bit prev_go;
        prev_shift = 1'b0;
        prev_go    = 1'b0;
        forever begin
            @(negedge game_clk);
            if (!reset) begin
                if (spawn_req)                note(EV_SPAWN, int'(phase));
                if (fall_en)                  note(EV_FALL, 0);
                if (lock_en)                  note(EV_LOCK, int'(phase));
                if (shift_req && !prev_shift) note(EV_SHIFT, int'(shift_row));
                if (game_over && !prev_go)    note(EV_GOVER, int'(phase));
            end
            prev_shift = shift_req;
            prev_go    = game_over;
        end
    end

    initial begin
        logic [ROWS-1:0] rows;
        reset = 1'b1; start = 1'b0; gravity_tick = 1'b0; move_valid = 1'b0;
        piece_touching = 1'b0; spawn_blocked = 1'b0; full_rows = '0; shift_done = 1'b0;
        repeat (2) tick();
        chk("rst_phase", int'(phase), 0);
        chk("rst_strobes", int'({spawn_req, fall_en, lock_en, shift_req, game_over}), 0);
        chk("rst_counts", int'(line_count) + int'(lines_last) + int'(shift_row), 0);
        chk("rst_move_ready", int'(move_ready), 0);
        reset = 1'b0;
        tick();

        // start -> SPAWN -> FALL with one spawn_req
        start = 1'b1; push(EV_SPAWN, 2); tick(); start = 1'b0;
        chk("phase_spawn", int'(phase), 1);
        tick();
        chk("spawn_req_pulse", int'(spawn_req), 1);
        chk("phase_fall", int'(phase), 2);
        tick();
        chk("spawn_req_single", int'(spawn_req), 0);

        // three free-fall ticks
        for (int i = 0; i < 3; i++) begin
            gravity_tick = 1'b1; push(EV_FALL, 0); tick(); gravity_tick = 1'b0;
            chk("fall_en_latency", int'(fall_en), 1);
            tick();
            chk("fall_en_single", int'(fall_en), 0);
        end

        // gravity beats a coincident move
        move_valid = 1'b1; gravity_tick = 1'b1; push(EV_FALL, 0);
        #1 chk("move_ready_stalled", int'(move_ready), 0);
        tick(); gravity_tick = 1'b0;
        #1 chk("move_ready_granted", int'(move_ready), 1);
        tick(); move_valid = 1'b0;

        // lock delay with a restart in between
        piece_touching = 1'b1; gravity_tick = 1'b1; tick(); gravity_tick = 1'b0;
        chk("no_lock_first_touch", int'(lock_en), 0);
        tick();
        piece_touching = 1'b0; gravity_tick = 1'b1; push(EV_FALL, 0); tick(); gravity_tick = 1'b0;
        tick();
        piece_touching = 1'b1; gravity_tick = 1'b1; tick(); gravity_tick = 1'b0;
        chk("no_lock_after_restart", int'(lock_en), 0);
        tick();
        gravity_tick = 1'b1; push(EV_LOCK, 3); tick(); gravity_tick = 1'b0;
        chk("lock_en_pulse", int'(lock_en), 1);
        chk("phase_lock", int'(phase), 3);
        piece_touching = 1'b0;
        rows = '0; rows[19] = 1'b1; rows[17] = 1'b1;
        full_rows = rows;

        // rows 19 and 17 full: shift 19, then 18 (old 17 dropped)
        push(EV_SHIFT, 19); push(EV_SHIFT, 18); push(EV_SPAWN, 2);
        do_shift(19);
        do_shift(18);
        wait_sig("spawn_after_clear", 1);
        chk("lines_last_a", int'(lines_last), 2);
        chk("line_count_a", int'(line_count), 2);

        // rows 19 and 18 full: row 19 is cleared twice
        rows = '0; rows[19] = 1'b1; rows[18] = 1'b1;
        lock_piece(rows);
        push(EV_SHIFT, 19); push(EV_SHIFT, 19); push(EV_SPAWN, 2);
        do_shift(19);
        do_shift(19);
        wait_sig("spawn_after_clear2", 1);
        chk("lines_last_b", int'(lines_last), 2);
        chk("line_count_b", int'(line_count), 4);

        // blocked spawn -> GAME_OVER without spawn_req
        spawn_blocked = 1'b1;
        lock_piece('0);
        push(EV_GOVER, 6);
        wait_sig("game_over_rise", 2);
        chk("phase_game_over", int'(phase), 6);
        chk("line_count_held", int'(line_count), 4);
        tick();
        chk("game_over_level", int'(game_over), 1);

        // restart from GAME_OVER clears the counters
        spawn_blocked = 1'b0; start = 1'b1; push(EV_SPAWN, 2); tick(); start = 1'b0;
        chk("line_count_cleared", int'(line_count), 0);
        chk("game_over_cleared", int'(game_over), 0);
        tick();
        chk("phase_fall_restart", int'(phase), 2);

        // reset in the middle of a shift handshake
        rows = '0; rows[19] = 1'b1;
        lock_piece(rows);
        push(EV_SHIFT, 19);
        wait_sig("shift_req_before_reset", 0);
        tick();
        #1 reset = 1'b1;
        #1 chk("async_shift_req_drop", int'(shift_req), 0);
        chk("async_phase_idle", int'(phase), 0);
        full_rows = '0;
        tick();
        reset = 1'b0;
        repeat (3) tick();
        chk("idle_after_reset", int'(phase), 0);
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
